// File: rtl/sad_pkg.sv
// Shared constants and FSM state type for the SAD minimum tracker.
package sad_pkg;

  localparam int unsigned SAD_W_DEF = 32;
  localparam logic [SAD_W_DEF-1:0] SAD_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } sad_state_e;

endpackage

// File: rtl/sad_pos_counter.sv
// Raster row/col position counter over latched search dimensions.
module sad_pos_counter #(
  parameter int unsigned ROW_W = 8,
  parameter int unsigned COL_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic [ROW_W-1:0] rows_i,
  input  logic [COL_W-1:0] cols_i,
  input  logic             advance_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             last_o
);

  logic [ROW_W-1:0] rows_q, rows_d, row_q, row_d;
  logic [COL_W-1:0] cols_q, cols_d, col_q, col_d;
  logic             col_last, row_last;

  assign col_last = (col_q == cols_q - COL_W'(1));
  assign row_last = (row_q == rows_q - ROW_W'(1));
  assign last_o   = col_last && row_last;
  assign row_o    = row_q;
  assign col_o    = col_q;

  always_comb begin
    rows_d = rows_q;
    cols_d = cols_q;
    row_d  = row_q;
    col_d  = col_q;
    if (clear_i) begin
      rows_d = rows_i;
      cols_d = cols_i;
      row_d  = '0;
      col_d  = '0;
    end else if (advance_i && !last_o) begin
      // Hold at the last position; never wrap past the grid.
      if (col_last) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rows_q <= '0;
      cols_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end else begin
      rows_q <= rows_d;
      cols_q <= cols_d;
      row_q  <= row_d;
      col_q  <= col_d;
    end
  end

endmodule

// File: rtl/sad_min_tracker.sv
// Tracks the minimum SAD and its raster position over a block-matching search.
// Optional macro SAD_ZERO_EXIT_EN: an accepted zero SAD ends the search early.
module sad_min_tracker
  import sad_pkg::*;
#(
  parameter int unsigned SAD_W = SAD_W_DEF,
  parameter int unsigned ROW_W = 8,
  parameter int unsigned COL_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [ROW_W-1:0] search_rows_i,
  input  logic [COL_W-1:0] search_cols_i,
  input  logic             sad_valid_i,
  input  logic [SAD_W-1:0] sad_i,
  output logic             sad_ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             result_valid_o,
  output logic [SAD_W-1:0] best_sad_o,
  output logic [ROW_W-1:0] best_row_o,
  output logic [COL_W-1:0] best_col_o
);

  localparam logic [SAD_W-1:0] SadNone = '1;

  sad_state_e       state_q, state_d;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic [ROW_W-1:0] best_row_q, best_row_d;
  logic [COL_W-1:0] best_col_q, best_col_d;
  logic             result_valid_q, result_valid_d;
  logic             cnt_clear, cnt_adv, cnt_last, accept;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;

  sad_pos_counter #(
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_pos (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (cnt_clear),
    .rows_i    (search_rows_i),
    .cols_i    (search_cols_i),
    .advance_i (cnt_adv),
    .row_o     (cur_row),
    .col_o     (cur_col),
    .last_o    (cnt_last)
  );

  assign sad_ready_o    = (state_q == SCAN);
  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == FIN);
  assign result_valid_o = result_valid_q;
  assign best_sad_o     = best_sad_q;
  assign best_row_o     = best_row_q;
  assign best_col_o     = best_col_q;
  assign accept         = sad_valid_i && sad_ready_o;

  always_comb begin
    state_d        = state_q;
    best_sad_d     = best_sad_q;
    best_row_d     = best_row_q;
    best_col_d     = best_col_q;
    result_valid_d = result_valid_q;
    cnt_clear      = 1'b0;
    cnt_adv        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_clear      = 1'b1;
          best_sad_d     = SadNone;
          best_row_d     = '0;
          best_col_d     = '0;
          result_valid_d = 1'b0;
          state_d = (search_rows_i != '0 && search_cols_i != '0) ? SCAN : FIN;
        end
      end
      SCAN: begin
        if (accept) begin
          // Strict compare: ties keep the earlier raster position.
          if (sad_i < best_sad_q) begin
            best_sad_d = sad_i;
            best_row_d = cur_row;
            best_col_d = cur_col;
          end
          cnt_adv = 1'b1;
          if (cnt_last) state_d = FIN;
`ifdef SAD_ZERO_EXIT_EN
          if (sad_i == '0) state_d = FIN;
`endif
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Result is flagged valid in the same cycle done pulses.
    if (state_d == FIN) result_valid_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      best_sad_q     <= SadNone;
      best_row_q     <= '0;
      best_col_q     <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      best_sad_q     <= best_sad_d;
      best_row_q     <= best_row_d;
      best_col_q     <= best_col_d;
      result_valid_q <= result_valid_d;
    end
  end

endmodule

// File: tb/tb_sad_min_tracker.sv
// Directed self-checking bench for sad_min_tracker (honours SAD_ZERO_EXIT_EN if defined).
module tb_sad_min_tracker;
  import sad_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, sad_valid;
  logic [7:0]  rows, cols;
  logic [31:0] sad_in;
  logic        sad_ready, busy, done, result_valid;
  logic [31:0] best_sad;
  logic [7:0]  best_row, best_col;

  int checks = 0;
  int fails = 0;
  int accepts = 0;

  always #5 clk = ~clk;

  sad_min_tracker dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .search_rows_i  (rows),
    .search_cols_i  (cols),
    .sad_valid_i    (sad_valid),
    .sad_i          (sad_in),
    .sad_ready_o    (sad_ready),
    .busy_o         (busy),
    .done_o         (done),
    .result_valid_o (result_valid),
    .best_sad_o     (best_sad),
    .best_row_o     (best_row),
    .best_col_o     (best_col)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic v, input logic [31:0] s);
    sad_valid = v;
    sad_in    = s;
    if (v && sad_ready) accepts++;
    tick();
    sad_valid = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] r, input logic [7:0] c);
    rows    = r;
    cols    = c;
    start   = 1'b1;
    accepts = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic [31:0] s, input logic [7:0] r,
                            input logic [7:0] c);
    chk({tag, ".done"}, done, 1'b1);
    chk({tag, ".rv"}, result_valid, 1'b1);
    chk({tag, ".sad"}, best_sad, s);
    chk({tag, ".row"}, best_row, r);
    chk({tag, ".col"}, best_col, c);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".ready"}, sad_ready, 1'b0);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".done"}, done, 1'b0);
    chk({tag, ".rv"}, result_valid, 1'b0);
    chk({tag, ".sad"}, best_sad, SAD_MAX);
    chk({tag, ".row"}, best_row, 8'd0);
    chk({tag, ".col"}, best_col, 8'd0);
  endtask

  logic [31:0] v6 [8];

  initial begin
    rst = 1'b1; start = 1'b0; sad_valid = 1'b0; sad_in = '0; rows = '0; cols = '0;
    tick(); tick();
    rst = 1'b0;
    chk_reset("reset");

    // 2x2, continuous valid, tie must keep earlier position.
    do_start(8'd2, 8'd2);
    chk("t1.ready", sad_ready, 1'b1);
    chk("t1.busy", busy, 1'b1);
    feed(1'b1, 32'd40); feed(1'b1, 32'd12); feed(1'b1, 32'd12);
    chk("t1.done_early", done, 1'b0);
    feed(1'b1, 32'd90);
    chk_result("t1", 32'd12, 8'd0, 8'd1);
    chk("t1.ready_fin", sad_ready, 1'b0);
    chk("t1.accepts", accepts, 4);
    tick();
    chk("t1.done_pulse", done, 1'b0);
    chk("t1.busy_idle", busy, 1'b0);
    chk("t1.rv_hold", result_valid, 1'b1);

    // 3x1 with valid gaps.
    do_start(8'd3, 8'd1);
    chk("t2.rv_clr", result_valid, 1'b0);
    feed(1'b1, 32'd7); feed(1'b0, 32'd1); feed(1'b0, 32'd1);
    feed(1'b1, 32'd3); feed(1'b0, 32'd0); feed(1'b1, 32'd5);
    chk_result("t2", 32'd3, 8'd1, 8'd0);
    chk("t2.accepts", accepts, 3);
    tick();

    // Zero rows: finishes immediately without consuming.
    do_start(8'd0, 8'd4);
    chk("t3.ready", sad_ready, 1'b0);
    chk_result("t3", SAD_MAX, 8'd0, 8'd0);
    tick();
    chk("t3.busy", busy, 1'b0);

    // Reset mid-search, then a clean rerun.
    do_start(8'd2, 8'd2);
    feed(1'b1, 32'd5); feed(1'b1, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("t4.rst");
    do_start(8'd2, 8'd2);
    feed(1'b1, 32'd8); feed(1'b1, 32'd6); feed(1'b1, 32'd7); feed(1'b1, 32'd9);
    chk_result("t4", 32'd6, 8'd1 - 8'd1, 8'd1);
    tick();

    // Start held high during scan and pulsed during FIN: ignored.
    do_start(8'd2, 8'd2);
    start = 1'b1;
    feed(1'b1, 32'd20); feed(1'b1, 32'd15); feed(1'b1, 32'd30); feed(1'b1, 32'd15);
    chk_result("t5", 32'd15, 8'd0, 8'd1);
    chk("t5.accepts", accepts, 4);
    tick();
    start = 1'b0;
    chk("t5.busy", busy, 1'b0);
    chk("t5.rv", result_valid, 1'b1);

    // 1x1 with the sentinel value: no update.
    do_start(8'd1, 8'd1);
    feed(1'b1, 32'hFFFF_FFFF);
    chk_result("t6", SAD_MAX, 8'd0, 8'd0);
    tick();

    // 2x3 containing a zero SAD.
    v6[0] = 32'd9; v6[1] = 32'd0; v6[2] = 32'd4; v6[3] = 32'd2;
    v6[4] = 32'd7; v6[5] = 32'd1; v6[6] = 32'd0; v6[7] = 32'd0;
    do_start(8'd2, 8'd3);
    for (int i = 0; i < 8 && sad_ready; i++) feed(1'b1, v6[i]);
    chk_result("t7", 32'd0, 8'd0, 8'd1);
`ifdef SAD_ZERO_EXIT_EN
    chk("t7.accepts", accepts, 2);
`else
    chk("t7.accepts", accepts, 6);
`endif
    tick();
    chk("t7.idle", busy, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
